cmp_result_filter: RTL and testbench
====================================

// Module: cmp_result_filter
// PURPOSE
//  Downstream of the 4-bit magnitude comparator. Consumes its greater/equal/less flags each
//  valid cycle and de-glitches them into a stable committed relation (GT/EQ/LT). A relation
//  is committed only after STABLE_N consecutive identical legal samples. Flags illegal flag
//  codes. Keeps saturating per-relation commit counters for system status reporting.
// PARAMETERS
//  STABLE_N  3  consecutive identical legal samples needed to commit (>=1)
//  CNT_W     8  width of each commit counter
// PORTS
//  clk        input   1      system clock, all state updates on rising edge
//  rst        input   1      synchronous, active-high reset
//  in_valid   input   1      gt/eq/lt sample valid this cycle
//  gt         input   1      comparator a>b flag
//  eq         input   1      comparator a==b flag
//  lt         input   1      comparator a<b flag
//  clr        input   1      synchronous clear of cnt_* only
//  st_gt      output  1      committed relation is GT
//  st_eq      output  1      committed relation is EQ
//  st_lt      output  1      committed relation is LT
//  st_valid   output  1      a relation has been committed since reset
//  change     output  1      1-cycle pulse: committed relation changed
//  err        output  1      1-cycle pulse: illegal flag code sampled
//  cnt_gt     output  CNT_W  commits into GT, saturating
//  cnt_eq     output  CNT_W  commits into EQ, saturating
//  cnt_lt     output  CNT_W  commits into LT, saturating
// BEHAVIOUR
//  - Reset: all outputs 0. FSM in INIT. Candidate cleared. Run count 0. rst beats every other input.
//  - FSM states: INIT (nothing committed), GT, EQ, LT. st_* are one-hot in GT/EQ/LT and all 0 in INIT.
//    st_valid=1 in every state except INIT. FSM never returns to INIT except through rst.
//  - A sample is accepted only when in_valid=1.
//    * in_valid=0: hold all state; run count is preserved, so gaps do not break a run.
//  - Legal sample: exactly one of gt/eq/lt is high. Any other code is illegal.
//    * On an illegal code: err=1 on the next cycle, candidate cleared, run=0, committed state unchanged.
//  - Legal sample handling:
//    * code==candidate: run=min(run+1,STABLE_N).
//    * otherwise: candidate=code, run=1.
//  - Commit: the accepted sample makes run==STABLE_N and candidate!=committed state.
//    * On that same edge: FSM moves to candidate, change=1 for one cycle, matching cnt_* increments.
//    * Latency: outputs reflect the STABLE_N-th sample one clock after it is presented.
//  - Samples that match the committed relation produce no change pulse and no count.
//  - Counters saturate at 2^CNT_W-1 and never wrap.
//  - clr=1: all cnt_* go to 0 on the next edge.
//    * If clr and a commit occur in the same cycle: clr wins (counts=0) while the FSM, change
//      and st_* still update.
//  - STABLE_N=1: every legal sample that differs from the committed relation commits immediately.
//  - Run counter width: $clog2(STABLE_N+1).
//  - rst asserted mid-run or mid-commit: return to reset values on the next edge; no pulse emitted.
// TESTING
//  1 rst=1 for 2 cycles with random flags -> all outputs 0, st_valid=0, no err/change.
//  2 STABLE_N=3, 3 valid lt samples -> after 3rd edge st_lt=1, st_valid=1, change pulse 1 cycle,
//    cnt_lt=1.
//  3 committed LT, samples gt,gt,lt,gt,gt -> no change; one more gt -> st_gt=1, cnt_gt=1, cnt_lt=1.
//  4 committed LT, samples eq,eq,{gt=1,eq=1},eq -> err pulse 1 cycle, no commit; eq,eq more -> EQ committed.
//  5 lt, in_valid=0 x4, lt, in_valid=0, lt -> LT committed on 3rd valid sample (gaps ignored).
//  6 CNT_W=2, 4 GT commits (alternating via EQ) -> cnt_gt=3 held. Then clr on the same cycle as an
//    EQ commit -> cnt_*=0, st_eq=1, change=1.
//  7 comparator in loop, b=4'b0101, a stepping 0..9 each held 3 valid cycles -> commits LT, EQ
//    (a=5), GT (a=6). Final cnt_lt=cnt_eq=cnt_gt=1. No err.

Source files
------------

// File: rtl/cmp_result_filter.sv
// cmp_result_filter: de-glitches comparator gt/eq/lt flags into a committed relation
// with illegal-code detection and saturating per-relation commit counters.
module cmp_result_filter #(
    parameter int STABLE_N = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             gt,
    input  logic             eq,
    input  logic             lt,
    input  logic             clr,
    output logic             st_gt,
    output logic             st_eq,
    output logic             st_lt,
    output logic             st_valid,
    output logic             change,
    output logic             err,
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_lt
);
    localparam int RW = $clog2(STABLE_N + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Candidate shares the state encoding; S_INIT doubles as "no candidate".
    localparam logic [1:0] S_INIT = 2'd0, S_GT = 2'd1, S_EQ = 2'd2, S_LT = 2'd3;

    logic [1:0]       state_q, state_d, cand_q, cand_d, code;
    logic [RW-1:0]    run_q, run_d;
    logic             change_q, change_d, err_q, err_d, legal, commit;
    logic [CNT_W-1:0] cnt_gt_q, cnt_gt_d, cnt_eq_q, cnt_eq_d, cnt_lt_q, cnt_lt_d;

    always_comb begin
        legal    = (gt ^ eq ^ lt) && !(gt && eq && lt);
        code     = gt ? S_GT : eq ? S_EQ : S_LT;
        state_d  = state_q;
        cand_d   = cand_q;
        run_d    = run_q;
        err_d    = 1'b0;
        change_d = 1'b0;
        commit   = 1'b0;
        if (in_valid && !legal) begin
            cand_d = S_INIT;
            run_d  = '0;
            err_d  = 1'b1;
        end else if (in_valid) begin
            cand_d = code;
            run_d  = (code != cand_q) ? RW'(1) : (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
            commit = (run_d == RUN_MAX) && (code != state_q);
        end
        if (commit) begin
            state_d  = code;
            change_d = 1'b1;
        end
        cnt_gt_d = clr ? '0 : (commit && code == S_GT && cnt_gt_q != CNT_MAX) ? cnt_gt_q + 1'b1 : cnt_gt_q;
        cnt_eq_d = clr ? '0 : (commit && code == S_EQ && cnt_eq_q != CNT_MAX) ? cnt_eq_q + 1'b1 : cnt_eq_q;
        cnt_lt_d = clr ? '0 : (commit && code == S_LT && cnt_lt_q != CNT_MAX) ? cnt_lt_q + 1'b1 : cnt_lt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_INIT;
            cand_q   <= S_INIT;
            run_q    <= '0;
            change_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_gt_q <= '0;
            cnt_eq_q <= '0;
            cnt_lt_q <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            run_q    <= run_d;
            change_q <= change_d;
            err_q    <= err_d;
            cnt_gt_q <= cnt_gt_d;
            cnt_eq_q <= cnt_eq_d;
            cnt_lt_q <= cnt_lt_d;
        end
    end

    assign st_gt    = state_q == S_GT;
    assign st_eq    = state_q == S_EQ;
    assign st_lt    = state_q == S_LT;
    assign st_valid = state_q != S_INIT;
    assign change   = change_q;
    assign err      = err_q;
    assign cnt_gt   = cnt_gt_q;
    assign cnt_eq   = cnt_eq_q;
    assign cnt_lt   = cnt_lt_q;
endmodule

// File: tb/tb_cmp_result_filter.sv
// tb_cmp_result_filter: directed checks of cmp_result_filter with hand-computed expectations;
// dut uses defaults, dut2 has CNT_W=2, dut3 has STABLE_N=1, all sharing one stimulus.
module tb_cmp_result_filter;
    logic clk = 1'b0, rst, in_valid, gt, eq, lt, clr;
    logic st_gt, st_eq, st_lt, st_valid, change, err;
    logic [7:0] cnt_gt, cnt_eq, cnt_lt;
    logic st_gt2, st_eq2, st_lt2, st_valid2, change2, err2;
    logic [1:0] cnt_gt2, cnt_eq2, cnt_lt2;
    logic st_gt3, st_eq3, st_lt3, st_valid3, change3, err3;
    logic [7:0] cnt_gt3, cnt_eq3, cnt_lt3;
    logic [5:0] st, st2, st3;
    int n_cmp = 0, n_bad = 0;

    localparam logic [2:0] G = 3'b100, E = 3'b010, L = 3'b001;

    cmp_result_filter #(.STABLE_N(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gt(gt), .eq(eq), .lt(lt), .clr(clr),
        .st_gt(st_gt), .st_eq(st_eq), .st_lt(st_lt), .st_valid(st_valid), .change(change),
        .err(err), .cnt_gt(cnt_gt), .cnt_eq(cnt_eq), .cnt_lt(cnt_lt));
    cmp_result_filter #(.STABLE_N(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gt(gt), .eq(eq), .lt(lt), .clr(clr),
        .st_gt(st_gt2), .st_eq(st_eq2), .st_lt(st_lt2), .st_valid(st_valid2), .change(change2),
        .err(err2), .cnt_gt(cnt_gt2), .cnt_eq(cnt_eq2), .cnt_lt(cnt_lt2));
    cmp_result_filter #(.STABLE_N(1), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gt(gt), .eq(eq), .lt(lt), .clr(clr),
        .st_gt(st_gt3), .st_eq(st_eq3), .st_lt(st_lt3), .st_valid(st_valid3), .change(change3),
        .err(err3), .cnt_gt(cnt_gt3), .cnt_eq(cnt_eq3), .cnt_lt(cnt_lt3));

    // Status packed as {st_valid, st_gt, st_eq, st_lt, change, err}.
    assign st  = {st_valid, st_gt, st_eq, st_lt, change, err};
    assign st2 = {st_valid2, st_gt2, st_eq2, st_lt2, change2, err2};
    assign st3 = {st_valid3, st_gt3, st_eq3, st_lt3, change3, err3};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] f, input logic c = 1'b0);
        in_valid = v;
        {gt, eq, lt} = f;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 3'($urandom));
        drive(1'b1, 3'($urandom));
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] a, b;
        int chg, errs;
        rst = 1'b1; in_valid = 1'b0; gt = 1'b0; eq = 1'b0; lt = 1'b0; clr = 1'b0;
        // reset with random flags
        drive(1'b1, 3'($urandom));
        chk("rst1_st", 32'(st), 0);
        drive(1'b1, 3'($urandom));
        chk("rst2_st", 32'(st), 0);
        chk("rst2_cnt", {cnt_gt, cnt_eq, cnt_lt}, 0);
        rst = 1'b0;
        // three LT samples commit
        drive(1'b1, L);
        chk("t2_s1", 32'(st), 0);
        chk("t2_n1_s1", 32'(st3), 6'b100110);
        drive(1'b1, L);
        chk("t2_s2", 32'(st), 0);
        drive(1'b1, L);
        chk("t2_s3", 32'(st), 6'b100110);
        chk("t2_cnt_lt", 32'(cnt_lt), 1);
        drive(1'b0, L);
        chk("t2_hold", 32'(st), 6'b100100);
        // interrupted GT run, then GT commit
        foreach (G[i]) begin end
        drive(1'b1, G); chk("t3_a", 32'(st), 6'b100100);
        drive(1'b1, G); chk("t3_b", 32'(st), 6'b100100);
        drive(1'b1, L); chk("t3_c", 32'(st), 6'b100100);
        drive(1'b1, G); chk("t3_d", 32'(st), 6'b100100);
        drive(1'b1, G); chk("t3_e", 32'(st), 6'b100100);
        drive(1'b1, G);
        chk("t3_commit", 32'(st), 6'b110010);
        chk("t3_cnt_gt", 32'(cnt_gt), 1);
        chk("t3_cnt_lt", 32'(cnt_lt), 1);
        // illegal code breaks an EQ run
        do_reset();
        repeat (3) drive(1'b1, L);
        drive(1'b1, E); chk("t4_e1", 32'(st), 6'b100100);
        drive(1'b1, E); chk("t4_e2", 32'(st), 6'b100100);
        drive(1'b1, G | E); chk("t4_err", 32'(st), 6'b100101);
        drive(1'b1, E); chk("t4_e3", 32'(st), 6'b100100);
        drive(1'b1, E); chk("t4_e4", 32'(st), 6'b100100);
        drive(1'b1, E);
        chk("t4_commit", 32'(st), 6'b101010);
        chk("t4_cnt_eq", 32'(cnt_eq), 1);
        drive(1'b1, 3'b000); chk("t4_err0", 32'(st), 6'b101001);
        drive(1'b0, 3'b111); chk("t4_noerr_inv", 32'(st), 6'b101000);
        // invalid gaps do not break a run
        do_reset();
        drive(1'b1, L);
        repeat (4) drive(1'b0, L);
        drive(1'b1, L); chk("t5_s2", 32'(st), 0);
        drive(1'b0, L); chk("t5_gap", 32'(st), 0);
        drive(1'b1, L);
        chk("t5_commit", 32'(st), 6'b100110);
        chk("t5_cnt_lt", 32'(cnt_lt), 1);
        // reset mid-run restarts the run
        do_reset();
        drive(1'b1, L);
        drive(1'b1, L);
        rst = 1'b1;
        drive(1'b1, L); chk("tr_rst", 32'(st), 0);
        rst = 1'b0;
        drive(1'b1, L); chk("tr_r1", 32'(st), 0);
        drive(1'b1, L); chk("tr_r2", 32'(st), 0);
        drive(1'b1, L); chk("tr_commit", 32'(st), 6'b100110);
        // saturation at CNT_W=2, then clr concurrent with a commit
        do_reset();
        for (int k = 0; k < 4; k++) begin
            repeat (3) drive(1'b1, G);
            if (k < 3) repeat (3) drive(1'b1, E);
        end
        chk("t6_sat_gt2", 32'(cnt_gt2), 3);
        chk("t6_sat_eq2", 32'(cnt_eq2), 3);
        chk("t6_gt_w8", 32'(cnt_gt), 4);
        drive(1'b1, E);
        drive(1'b1, E);
        drive(1'b1, E, 1'b1);
        chk("t6_clr_st", 32'(st2), 6'b101010);
        chk("t6_clr_cnt2", {cnt_gt2, cnt_eq2, cnt_lt2}, 0);
        chk("t6_clr_cnt", {cnt_gt, cnt_eq, cnt_lt}, 0);
        drive(1'b0, E);
        chk("t6_after_st", 32'(st2), 6'b101000);
        chk("t6_after_cnt", 32'(cnt_eq2), 0);
        // comparator sweep with b=5
        do_reset();
        b = 4'b0101;
        chg = 0;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            a = 4'(i);
            repeat (3) begin
                drive(1'b1, {a > b, a == b, a < b});
                chg += int'(change);
                errs += int'(err);
            end
        end
        chk("t7_changes", 32'(chg), 3);
        chk("t7_errs", 32'(errs), 0);
        chk("t7_st", 32'(st), 6'b110000);
        chk("t7_cnts", {cnt_gt, cnt_eq, cnt_lt}, {8'd1, 8'd1, 8'd1});
        chk("t7_n1_cnts", {cnt_gt3, cnt_eq3, cnt_lt3}, {8'd1, 8'd1, 8'd1});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
